multi_blink_controller: RTL and testbench

//  Multi-channel LED pattern generator. It generalises the single-channel,

---
 rtl/multi_blink_controller.sv | 132 +++++++++++++
 tb/tb_multi_blink_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_blink_controller.sv
// Multi-channel LED pattern generator: per-channel OFF / ON / BLINK / BURST
// modes with a millisecond half-period, all channels paced by one shared
// free-running millisecond prescaler. Config is written one channel per cycle.
module multi_blink_controller #(
  parameter int CHANNELS = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SPEED_W  = 16,
  parameter int CNT_W    = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  cfg_ch,
  input  logic [1:0]                                           cfg_mode,
  input  logic [SPEED_W-1:0]                                   cfg_speed,
  input  logic [CNT_W-1:0]                                     cfg_count,
  output logic [CHANNELS-1:0]                                  led,
  output logic [CHANNELS-1:0]                                  busy,
  output logic [CHANNELS-1:0]                                  done
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV   = CLK_HZ / 1000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic             cfg_ok;

  assign tick   = (pre_q == PRE_W'(DIV - 1));
  assign cfg_ok = (32'(cfg_ch) < 32'(CHANNELS));

  // Shared millisecond prescaler, never restarted by config writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]         mode_q;
    logic [SPEED_W-1:0] lim_q;     // max(speed,1)-1, precomputed at write time
    logic [SPEED_W-1:0] phase_q;
    logic [CNT_W-1:0]   pulses_q;
    logic               led_q;
    logic               busy_q;
    logic               done_q;
    logic               sel;

    assign sel = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));

    // Channel state: a write always wins over a pending toggle; busy marks
    // the two timed modes, so only those advance the phase counter.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mode_q   <= MODE_OFF;
        lim_q    <= '0;
        phase_q  <= '0;
        pulses_q <= '0;
        led_q    <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (sel) begin
          mode_q   <= cfg_mode;
          lim_q    <= (cfg_speed == '0) ? '0 : cfg_speed - 1'b1;
          phase_q  <= '0;
          pulses_q <= cfg_count;
          case (cfg_mode)
            MODE_OFF: begin
              led_q  <= 1'b0;
              busy_q <= 1'b0;
            end
            MODE_ON: begin
              led_q  <= 1'b1;
              busy_q <= 1'b0;
            end
            MODE_BLINK: begin
              led_q  <= 1'b1;
              busy_q <= 1'b1;
            end
            default: begin
              if (cfg_count == '0) begin
                mode_q <= MODE_OFF;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                led_q  <= 1'b1;
                busy_q <= 1'b1;
              end
            end
          endcase
        end else if (busy_q && tick) begin
          if (phase_q == lim_q) begin
            phase_q <= '0;
            if ((mode_q == MODE_BURST) && led_q) begin
              led_q <= 1'b0;
              if (pulses_q == CNT_W'(1)) begin
                mode_q   <= MODE_OFF;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                pulses_q <= '0;
              end else begin
                pulses_q <= pulses_q - 1'b1;
              end
            end else begin
              led_q <= ~led_q;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
      end
    end

    assign led[i]  = led_q;
    assign busy[i] = busy_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_multi_blink_controller.sv
// Directed bench for multi_blink_controller: 4 channels, 10 clocks per ms.
// Expected run lengths are queued when a channel is configured and popped
// as each high/low run of the LED is measured.
module tb_multi_blink_controller;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;
  localparam int RUN_LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_speed;
  logic [7:0]  cfg_count;
  logic [3:0]  led;
  logic [3:0]  busy;
  logic [3:0]  done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    lo;
    int    hi;
  } exp_t;

  exp_t sb_q[$];

  multi_blink_controller #(
    .CHANNELS(4),
    .CLK_HZ  (10_000),
    .SPEED_W (16),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_speed(cfg_speed),
    .cfg_count(cfg_count),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input string tag, input int lo, input int hi);
    exp_t e;
    e.tag = tag;
    e.lo  = lo;
    e.hi  = hi;
    sb_q.push_back(e);
  endtask

  // Count negedge samples while led[ch] holds lvl, then score against the queue
  task automatic check_run(input int ch, input logic lvl);
    int   len;
    exp_t e;
    logic ok;
    len = 0;
    while ((led[ch] === lvl) && (len < RUN_LIMIT)) begin
      len++;
      @(negedge clk);
    end
    checks++;
    if (sb_q.size() == 0) begin
      e.tag = "sb_empty";
      e.lo  = -1;
      e.hi  = -1;
    end else begin
      e = sb_q.pop_front();
    end
    ok = (len >= e.lo) && (len <= e.hi);
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", e.tag, len, e.lo, e.hi);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the write edge
  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [15:0] speed, input logic [7:0] count);
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_speed = speed;
    cfg_count = count;
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] acc;
    logic       on_acc;

    rst       = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_speed = '0;
    cfg_count = '0;

    // 1. reset, then idle
    #1;
    chk("rst_async_led", 32'(led), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    chk("rst_async_done", 32'(done), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b1;
    acc = '0;
    repeat (1000) begin
      @(negedge clk);
      acc = acc | led | busy | done;
    end
    chk("idle_outputs", 32'(acc), 32'h0);

    // 2. ch0 BLINK speed=5
    write_cfg(2'd0, MODE_BLINK, 16'd5, 8'd0);
    expect_run("ch0_first_hi", 40, 50);
    expect_run("ch0_lo", 50, 50);
    expect_run("ch0_hi", 50, 50);
    chk("ch0_led_after_write", 32'(led[0]), 32'h1);
    chk("ch0_busy", 32'(busy[0]), 32'h1);
    chk("ch321_led_quiet", 32'(led[3:1]), 32'h0);
    check_run(0, 1'b1);
    check_run(0, 1'b0);
    check_run(0, 1'b1);

    // 3. ch1 BURST speed=2 count=3
    write_cfg(2'd1, MODE_BURST, 16'd2, 8'd3);
    expect_run("ch1_p1_hi", 10, 20);
    expect_run("ch1_p1_lo", 20, 20);
    expect_run("ch1_p2_hi", 20, 20);
    expect_run("ch1_p2_lo", 20, 20);
    expect_run("ch1_p3_hi", 20, 20);
    chk("ch1_led_after_write", 32'(led[1]), 32'h1);
    chk("ch1_busy", 32'(busy[1]), 32'h1);
    check_run(1, 1'b1);
    check_run(1, 1'b0);
    check_run(1, 1'b1);
    check_run(1, 1'b0);
    check_run(1, 1'b1);
    chk("ch1_done_pulse", 32'(done[1]), 32'h1);
    chk("ch1_busy_end", 32'(busy[1]), 32'h0);
    chk("ch1_led_end", 32'(led[1]), 32'h0);
    @(negedge clk);
    chk("ch1_done_one_cycle", 32'(done[1]), 32'h0);
    acc = '0;
    repeat (100) begin
      @(negedge clk);
      acc[0] = acc[0] | led[1] | busy[1] | done[1];
    end
    chk("ch1_stays_off", 32'(acc[0]), 32'h0);

    // 4. ch2 ON, then BLINK speed=0 with an unrelated write to ch3
    write_cfg(2'd2, MODE_ON, 16'd0, 8'd0);
    chk("ch2_on_led", 32'(led[2]), 32'h1);
    chk("ch2_on_busy", 32'(busy[2]), 32'h0);
    on_acc = 1'b1;
    repeat (50) begin
      @(negedge clk);
      on_acc = on_acc & led[2];
    end
    chk("ch2_on_steady", 32'(on_acc), 32'h1);
    write_cfg(2'd2, MODE_BLINK, 16'd0, 8'd0);
    expect_run("ch2_first_hi", 0, 10);
    expect_run("ch2_lo", 10, 10);
    expect_run("ch2_hi", 10, 10);
    chk("ch2_blink_busy", 32'(busy[2]), 32'h1);
    check_run(2, 1'b1);
    fork
      check_run(2, 1'b0);
      write_cfg(2'd3, MODE_OFF, 16'd0, 8'd0);
    join
    check_run(2, 1'b1);
    chk("ch3_off_led", 32'(led[3]), 32'h0);
    chk("ch3_off_busy", 32'(busy[3]), 32'h0);

    // 5. ch0 rewritten mid-blink, ch3 BURST with count=0
    write_cfg(2'd0, MODE_BLINK, 16'd2, 8'd0);
    expect_run("ch0_re_first_hi", 10, 20);
    expect_run("ch0_re_lo", 20, 20);
    expect_run("ch0_re_hi", 20, 20);
    chk("ch0_re_led", 32'(led[0]), 32'h1);
    chk("ch0_re_busy", 32'(busy[0]), 32'h1);
    check_run(0, 1'b1);
    check_run(0, 1'b0);
    check_run(0, 1'b1);
    write_cfg(2'd3, MODE_BURST, 16'd4, 8'd0);
    chk("ch3_zero_done", 32'(done[3]), 32'h1);
    chk("ch3_zero_led", 32'(led[3]), 32'h0);
    chk("ch3_zero_busy", 32'(busy[3]), 32'h0);
    @(negedge clk);
    chk("ch3_zero_done_clear", 32'(done[3]), 32'h0);
    chk("ch3_zero_led_still", 32'(led[3]), 32'h0);

    // 6. asynchronous reset mid-burst on ch1
    write_cfg(2'd1, MODE_BURST, 16'd3, 8'd5);
    chk("ch1_b2_led", 32'(led[1]), 32'h1);
    repeat (15) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_led1", 32'(led[1]), 32'h0);
    chk("midrst_busy1", 32'(busy[1]), 32'h0);
    chk("midrst_led_all", 32'(led), 32'h0);
    acc = done;
    repeat (3) begin
      @(negedge clk);
      acc = acc | done;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      acc = acc | done;
    end
    chk("midrst_no_done", 32'(acc), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
